// File: rtl/bitfusion_input_skewer.sv
// Diagonal input skewer for a BitFusion PE column: lane k is delayed by k cycles
// so each PE sees its activation alongside the registered partial sum from PE k-1.
module bitfusion_input_skewer #(
  parameter int unsigned LANES = 16,
  parameter int unsigned DW    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*DW-1:0]   in_vec,
  input  logic                  flush,
  output logic [LANES*DW-1:0]   skew_out,
  output logic [LANES-1:0]      lane_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [LANES-1:0] vld, vld_nxt;
  logic             accept;
  logic             done_nxt;
  logic             busy_nxt;

  assign in_ready   = (state != DRAIN);
  assign accept     = in_valid && in_ready;
  assign vld_nxt    = (vld << 1) | LANES'(accept);
  assign lane_valid = vld;

  // Next-state, drain counter and registered-output precompute
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (flush) begin
          state_nxt = DRAIN;
          cnt_nxt   = CW'(LANES - 1);
        end else if (accept) begin
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (flush) begin
          state_nxt = DRAIN;
          cnt_nxt   = CW'(LANES - 1);
        end else if (vld_nxt == '0) begin
          state_nxt = IDLE;
        end
      end
      DRAIN: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt <= CW'(1)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (vld_nxt != '0) || (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      vld   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      vld   <= vld_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // Per-lane delay chain of depth k+1; bubbles shift in as zero data
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [DW-1:0] chain [k+1];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int j = 0; j <= k; j++) chain[j] <= '0;
      end else begin
        chain[0] <= accept ? in_vec[k*DW +: DW] : '0;
        for (int j = 1; j <= k; j++) chain[j] <= chain[j-1];
      end
    end

    assign skew_out[k*DW +: DW] = chain[k];
  end

endmodule

// File: tb/tb_bitfusion_input_skewer.sv
// Directed bench for bitfusion_input_skewer: reset, single beat, streaming,
// bubbles, flush with same-cycle accept, idle flush and reset mid-drain.
module tb_bitfusion_input_skewer;

  localparam int unsigned LANES = 16;
  localparam int unsigned DW    = 32;
  localparam int unsigned VW    = LANES * DW;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [VW-1:0]    in_vec;
  logic             flush;
  logic [VW-1:0]    skew_out;
  logic [LANES-1:0] lane_valid;
  logic             busy;
  logic             done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bitfusion_input_skewer #(.LANES(LANES), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_vec     (in_vec),
    .flush      (flush),
    .skew_out   (skew_out),
    .lane_valid (lane_valid),
    .busy       (busy),
    .done       (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] fill_vec(input logic [31:0] base);
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < int'(LANES); k++) v[k*DW +: DW] = base + 32'(k);
    return v;
  endfunction

  function automatic logic [DW-1:0] lane_of(input logic [VW-1:0] v, input int k);
    return v[k*DW +: DW];
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_skew"},  skew_out, '0);
    chk({tag, "_valid"}, VW'(lane_valid), '0);
    chk({tag, "_busy"},  VW'(busy), '0);
    chk({tag, "_done"},  VW'(done), '0);
    chk({tag, "_ready"}, VW'(in_ready), VW'(1));
  endtask

  initial begin
    logic [VW-1:0]    ev;
    logic [LANES-1:0] el;
    logic [VW-1:0]    xv;
    logic             seen_done;
    int               b;

    reset = 1'b0; in_valid = 1'b0; flush = 1'b0; in_vec = '0;

    // Reset hold and release
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("in_reset");
    reset = 1'b1;
    tick();
    tick();
    chk_idle_outputs("post_reset");

    // Single beat walks the diagonal
    in_vec = fill_vec(32'hA000_0000);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_vec = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      if (k > 0) tick();
      ev = '0;
      ev[k*DW +: DW] = 32'hA000_0000 + 32'(k);
      chk($sformatf("single_data_%0d", k), skew_out, ev);
      chk($sformatf("single_valid_%0d", k), VW'(lane_valid), VW'(LANES'(1) << k));
    end
    tick();
    chk_idle_outputs("single_after");

    // Twenty back-to-back beats: lane k carries beat t-k
    for (int t = 0; t < 36; t++) begin
      in_valid = (t < 20);
      in_vec = '0;
      if (t < 20)
        for (int k = 0; k < int'(LANES); k++) in_vec[k*DW +: DW] = {16'(t), 16'(k)};
      tick();
      ev = '0;
      el = '0;
      for (int k = 0; k < int'(LANES); k++) begin
        b = t - k;
        if (b >= 0 && b < 20) begin
          ev[k*DW +: DW] = {16'(b), 16'(k)};
          el[k] = 1'b1;
        end
      end
      chk($sformatf("stream_data_t%0d", t), skew_out, ev);
      chk($sformatf("stream_valid_t%0d", t), VW'(lane_valid), VW'(el));
    end
    in_valid = 1'b0;
    tick();
    chk_idle_outputs("stream_after");

    // Bubble between beats at edges 0 and 2
    in_vec = fill_vec(32'hB000_0000); in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_vec = '0;
    tick();
    in_vec = fill_vec(32'hC000_0000); in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_vec = '0;
    tick();
    chk("bubble_l3_e3", VW'(lane_of(skew_out, 3)), VW'(32'hB000_0003));
    chk("bubble_v3_e3", VW'(lane_valid[3]), VW'(1));
    tick();
    chk("bubble_l3_e4", VW'(lane_of(skew_out, 3)), '0);
    chk("bubble_v3_e4", VW'(lane_valid[3]), '0);
    chk("bubble_l2_e4", VW'(lane_of(skew_out, 2)), VW'(32'hC000_0002));
    tick();
    chk("bubble_l3_e5", VW'(lane_of(skew_out, 3)), VW'(32'hC000_0003));
    chk("bubble_v3_e5", VW'(lane_valid[3]), VW'(1));
    repeat (16) tick();
    chk_idle_outputs("bubble_after");

    // Flush with same-cycle accept; in_valid stays high during the drain
    xv = fill_vec(32'hD000_0000);
    in_vec = xv; in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    in_vec = fill_vec(32'hE000_0000);
    for (int j = 0; j < int'(LANES) - 1; j++) begin
      if (j > 0) begin
        flush = (j == 7);
        tick();
      end
      chk($sformatf("drain_ready_%0d", j), VW'(in_ready), '0);
      chk($sformatf("drain_valid_%0d", j), VW'(lane_valid), VW'(LANES'(1) << j));
      chk($sformatf("drain_done_%0d", j), VW'(done), '0);
      chk($sformatf("drain_busy_%0d", j), VW'(busy), VW'(1));
    end
    flush = 1'b0;
    tick();
    chk("flush_done", VW'(done), VW'(1));
    chk("flush_l15", VW'(lane_of(skew_out, 15)), VW'(lane_of(xv, 15)));
    chk("flush_valid", VW'(lane_valid), VW'(LANES'(1) << (LANES - 1)));
    chk("flush_ready", VW'(in_ready), VW'(1));
    in_valid = 1'b0; in_vec = '0;
    tick();
    chk_idle_outputs("flush_after");

    // Flush from IDLE with an empty pipeline still runs the full drain
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("idle_flush_ready", VW'(in_ready), '0);
    chk("idle_flush_busy", VW'(busy), VW'(1));
    repeat (14) tick();
    chk("idle_flush_done_early", VW'(done), '0);
    tick();
    chk("idle_flush_done", VW'(done), VW'(1));
    chk("idle_flush_valid", VW'(lane_valid), '0);
    tick();
    chk_idle_outputs("idle_flush_after");

    // Reset five cycles into a drain
    in_vec = fill_vec(32'hF000_0000); in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0; in_vec = '0;
    repeat (5) tick();
    chk("pre_reset_valid", VW'(lane_valid), VW'(LANES'(1) << 5));
    reset = 1'b0;
    #1;
    chk_idle_outputs("mid_drain_reset");
    seen_done = 1'b0;
    repeat (2) begin
      tick();
      seen_done = seen_done | done;
    end
    reset = 1'b1;
    repeat (20) begin
      tick();
      seen_done = seen_done | done;
    end
    chk("no_done_after_reset", VW'(seen_done), '0);
    chk_idle_outputs("reset_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bitfusion_input_skewer.md
# bitfusion_input_skewer

Upstream feeder for the 16-PE BitFusion column. It accepts one vector of 16 pre-sorted 32-bit activation words per handshake and delays lane k by k cycles. This diagonal (systolic) timing matches the partial sum as it ripples through the per-PE sum registers, so PE k+1 sees its activation in the same cycle as PE k's registered sum. It sits between the activation buffer and the column's `sorted_input_1..16` ports, and provides a flush/drain sequence that empties the skew pipeline with zero bubbles.

## Interface
- `LANES`, default 16: number of lanes, equal to the PEs per column.
- `DW`, default 32: lane word width in bits.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: `in_vec` holds a valid activation vector.
- `in_ready`, output, 1: the block can accept a vector this cycle.
- `in_vec`, input, LANES*DW: lane k is bits [k*DW+DW-1 : k*DW].
- `flush`, input, 1: request to drain the skew pipeline.
- `skew_out`, output, LANES*DW: lane k drives column input k+1. Same bit packing as `in_vec`.
- `lane_valid`, output, LANES: bit k is high when lane k of `skew_out` carries real data.
- `busy`, output, 1: high when any stage holds valid data or the FSM is not IDLE.
- `done`, output, 1: one-cycle pulse at the end of a drain.

## Operation
- Accept condition: `in_valid && in_ready` at a rising edge.
- Lane k has a register chain of depth k+1. Lane 0 has one register; lane 15 has 16.
- The pipeline is free-running with no downstream backpressure; the column has no stall input.
- Each cycle with no accept, a bubble enters every lane: data 0, valid 0.
- Bubble lanes output all-zero data. `skew_out` never shows stale data when its `lane_valid` bit is 0.
- FSM states:
  - IDLE: pipeline empty, `in_ready` = 1.
  - STREAM: at least one valid stage, `in_ready` = 1.
  - DRAIN: `in_ready` = 0.
- Transitions:
  - IDLE → STREAM on an accept.
  - STREAM → IDLE when all valid stages are empty and there is no accept.
  - IDLE or STREAM → DRAIN when `flush` is sampled high. A beat accepted at that same edge is kept and drained normally.
  - DRAIN → IDLE when the drain counter expires.
- Drain counter: 4 bits (width clog2(LANES)). Loaded with LANES-1 on entry to DRAIN and decremented every cycle in DRAIN. It expires when it reaches 0.
- `flush` while in DRAIN is ignored, and the counter is not reloaded.
- `flush` in IDLE with an empty pipeline still runs a full LANES-1-cycle drain and ends with `done`.
- `done` is registered. It is high for exactly one cycle, the cycle after the DRAIN → IDLE edge.
- No arithmetic is performed on data. Words pass bit-exact, and `sign_x` / bitwidth handling stays downstream.

## Timing
- Reset (asynchronous, while `reset` = 0):
  - All data stages = 0, all valid stages = 0, FSM = IDLE, counter = 0.
  - Outputs: `skew_out` = 0, `lane_valid` = 0, `busy` = 0, `done` = 0, `in_ready` = 1.
- Latency: a vector accepted at edge n appears on lane k during the cycle after edge n+k, with `lane_valid[k]` = 1.
- Back-to-back accepts every cycle give full throughput: one vector per cycle.
- In steady state `lane_valid` forms a staircase.
- Drain timing:
  - `flush` sampled at edge n: DRAIN runs during the cycles after edges n..n+14.
  - The FSM returns to IDLE at edge n+15.
  - `done` = 1 in the cycle after edge n+15. This is the same cycle lane 15 shows the last accepted beat.
- `busy` falls in the cycle after the last valid stage empties.
- Reset asserted mid-stream or mid-drain clears everything immediately. No `done` is issued.
- `in_ready` is combinational from FSM state only. There is no path from `in_valid` to `in_ready`.

## Test plan
- Reset release: hold `reset` = 0 for 3 cycles, then release. All outputs are 0 except `in_ready` = 1, and they stay that way with `in_valid` = 0.
- Single beat: accept vector lane k = 32'hA000_0000 + k at edge 0. Lane k shows that value after edge k, only for one cycle. `lane_valid` is one-hot walking bit 0 → 15.
- Streaming: 20 consecutive beats where beat b, lane k = {b[15:0], k[15:0]}.
  - Every cycle, lane k equals beat (t−k).
  - Every bubble lane reads 0.
- Bubble insertion: beats at edges 0 and 2, idle at edge 1. Lane 3 shows beat 0 after edge 3, zero with valid 0 after edge 4, and beat 2 after edge 5.
- Flush with same-cycle accept: accept beat X with `flush` = 1 at edge 10.
  - `in_ready` = 0 for the next 15 cycles.
  - `in_valid` held high during that time is not accepted.
  - `done` = 1 after edge 25, the same cycle lane 15 = X.
  - Then IDLE and `busy` = 0.
- Reset mid-drain: assert `reset` 5 cycles into DRAIN. All outputs are cleared immediately, `done` never pulses, and `in_ready` = 1 after release.
